// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcodes, bus widths and entry states.
// No logic; imported by alu_rs and its bench.
package alu_rs_pkg;

  localparam int OpSize      = 5;
  localparam int REGSize     = 32;
  localparam int RegAddrSize = 4;

  localparam logic [OpSize-1:0] OP_NOP  = 5'd0;
  localparam logic [OpSize-1:0] OP_ADD  = 5'd1;
  localparam logic [OpSize-1:0] OP_SUB  = 5'd2;
  localparam logic [OpSize-1:0] OP_AND  = 5'd3;
  localparam logic [OpSize-1:0] OP_OR   = 5'd4;
  localparam logic [OpSize-1:0] OP_XOR  = 5'd5;
  localparam logic [OpSize-1:0] OP_SLL  = 5'd6;
  localparam logic [OpSize-1:0] OP_SRL  = 5'd7;
  localparam logic [OpSize-1:0] OP_SRA  = 5'd8;
  localparam logic [OpSize-1:0] OP_SLT  = 5'd9;
  localparam logic [OpSize-1:0] OP_SLTU = 5'd10;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } rs_state_e;

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder giving one-hot grant, binary index and found flag.
// Combinational, zero latency; no backpressure.
module rs_pick #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the lowest requesting index is the last writer.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands arrive on a CDB, then issues.
// Issue 1 cycle after READY (dispatch-to-issue >= 2); dispatch is refused while full is high.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = RegAddrSize
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               disp_valid,
  input  logic [OpSize-1:0]  disp_op,
  input  logic [REGSize-1:0] disp_vj,
  input  logic [REGSize-1:0] disp_vk,
  input  logic               disp_qj_busy,
  input  logic               disp_qk_busy,
  input  logic [TAG_W-1:0]   disp_qj,
  input  logic [TAG_W-1:0]   disp_qk,
  input  logic [TAG_W-1:0]   disp_rob,
  output logic               full,
  input  logic               cdb0_valid,
  input  logic [TAG_W-1:0]   cdb0_rob,
  input  logic [REGSize-1:0] cdb0_val,
  input  logic               cdb1_valid,
  input  logic [TAG_W-1:0]   cdb1_rob,
  input  logic [REGSize-1:0] cdb1_val,
  output logic               alu_status,
  output logic [OpSize-1:0]  alu_op,
  output logic [REGSize-1:0] alu_rs1,
  output logic [REGSize-1:0] alu_rs2,
  output logic [TAG_W-1:0]   alu_rob
);

  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    rs_state_e          state;
    logic [OpSize-1:0]  op;
    logic [REGSize-1:0] vj;
    logic [REGSize-1:0] vk;
    logic               qj_busy;
    logic               qk_busy;
    logic [TAG_W-1:0]   qj;
    logic [TAG_W-1:0]   qk;
    logic [TAG_W-1:0]   rob;
  } entry_t;

  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];

  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] busy_d;
  logic [RS_SIZE-1:0] free_oh;
  logic [RS_SIZE-1:0] ready_oh;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   ready_idx;
  logic               free_found;
  logic               ready_found;
  logic               disp_take;
  logic               full_d;
  logic               unused_free_idx;

  function automatic logic cdb_hit(input logic vld, input logic [TAG_W-1:0] bus_tag,
                                   input logic [TAG_W-1:0] want);
    return vld && (bus_tag == want);
  endfunction

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = (ent_q[i].state == ST_FREE);
      ready_vec[i] = (ent_q[i].state == ST_READY);
    end
  end

  rs_pick #(.N(RS_SIZE), .IW(IDX_W)) u_pick_free (
    .req    (free_vec),
    .onehot (free_oh),
    .idx    (free_idx),
    .found  (free_found)
  );

  rs_pick #(.N(RS_SIZE), .IW(IDX_W)) u_pick_ready (
    .req    (ready_vec),
    .onehot (ready_oh),
    .idx    (ready_idx),
    .found  (ready_found)
  );

  assign unused_free_idx = ^free_idx;
  assign disp_take       = disp_valid && !full && free_found;

  // An entry issuing this cycle is still READY, so it is never the free pick.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];

      if (ent_q[i].state == ST_WAIT) begin
        if (ent_q[i].qj_busy) begin
          if (cdb_hit(cdb0_valid, cdb0_rob, ent_q[i].qj)) begin
            ent_d[i].vj      = cdb0_val;
            ent_d[i].qj_busy = 1'b0;
          end else if (cdb_hit(cdb1_valid, cdb1_rob, ent_q[i].qj)) begin
            ent_d[i].vj      = cdb1_val;
            ent_d[i].qj_busy = 1'b0;
          end
        end
        if (ent_q[i].qk_busy) begin
          if (cdb_hit(cdb0_valid, cdb0_rob, ent_q[i].qk)) begin
            ent_d[i].vk      = cdb0_val;
            ent_d[i].qk_busy = 1'b0;
          end else if (cdb_hit(cdb1_valid, cdb1_rob, ent_q[i].qk)) begin
            ent_d[i].vk      = cdb1_val;
            ent_d[i].qk_busy = 1'b0;
          end
        end
        if (!ent_d[i].qj_busy && !ent_d[i].qk_busy) begin
          ent_d[i].state = ST_READY;
        end
      end

      if (ready_oh[i]) begin
        ent_d[i].state = ST_FREE;
      end

      if (disp_take && free_oh[i]) begin
        ent_d[i].op      = disp_op;
        ent_d[i].rob     = disp_rob;
        ent_d[i].qj      = disp_qj;
        ent_d[i].qk      = disp_qk;
        ent_d[i].vj      = disp_vj;
        ent_d[i].vk      = disp_vk;
        ent_d[i].qj_busy = disp_qj_busy;
        ent_d[i].qk_busy = disp_qk_busy;
        if (disp_qj_busy && cdb_hit(cdb0_valid, cdb0_rob, disp_qj)) begin
          ent_d[i].vj      = cdb0_val;
          ent_d[i].qj_busy = 1'b0;
        end else if (disp_qj_busy && cdb_hit(cdb1_valid, cdb1_rob, disp_qj)) begin
          ent_d[i].vj      = cdb1_val;
          ent_d[i].qj_busy = 1'b0;
        end
        if (disp_qk_busy && cdb_hit(cdb0_valid, cdb0_rob, disp_qk)) begin
          ent_d[i].vk      = cdb0_val;
          ent_d[i].qk_busy = 1'b0;
        end else if (disp_qk_busy && cdb_hit(cdb1_valid, cdb1_rob, disp_qk)) begin
          ent_d[i].vk      = cdb1_val;
          ent_d[i].qk_busy = 1'b0;
        end
        ent_d[i].state = (ent_d[i].qj_busy || ent_d[i].qk_busy) ? ST_WAIT : ST_READY;
      end
    end
  end

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_d[i] = (ent_d[i].state != ST_FREE);
    end
  end

  assign full_d = &busy_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      full       <= 1'b0;
      alu_status <= 1'b0;
      alu_op     <= '0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_rob    <= '0;
    end else if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      full       <= 1'b0;
      alu_status <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
      full       <= full_d;
      alu_status <= ready_found;
      if (ready_found) begin
        alu_op  <= ent_q[ready_idx].op;
        alu_rs1 <= ent_q[ready_idx].vj;
        alu_rs2 <= ent_q[ready_idx].vk;
        alu_rob <= ent_q[ready_idx].rob;
      end
    end else begin
      alu_status <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: expected issues are queued at dispatch and checked when alu_status fires.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int RS_SIZE = 8;
  localparam int TAG_W   = 4;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               rdy_in;
  logic               clear;
  logic               disp_valid;
  logic [OpSize-1:0]  disp_op;
  logic [31:0]        disp_vj;
  logic [31:0]        disp_vk;
  logic               disp_qj_busy;
  logic               disp_qk_busy;
  logic [TAG_W-1:0]   disp_qj;
  logic [TAG_W-1:0]   disp_qk;
  logic [TAG_W-1:0]   disp_rob;
  logic               full;
  logic               cdb0_valid;
  logic [TAG_W-1:0]   cdb0_rob;
  logic [31:0]        cdb0_val;
  logic               cdb1_valid;
  logic [TAG_W-1:0]   cdb1_rob;
  logic [31:0]        cdb1_val;
  logic               alu_status;
  logic [OpSize-1:0]  alu_op;
  logic [31:0]        alu_rs1;
  logic [31:0]        alu_rs2;
  logic [TAG_W-1:0]   alu_rob;

  alu_rs #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear        (clear),
    .disp_valid   (disp_valid),
    .disp_op      (disp_op),
    .disp_vj      (disp_vj),
    .disp_vk      (disp_vk),
    .disp_qj_busy (disp_qj_busy),
    .disp_qk_busy (disp_qk_busy),
    .disp_qj      (disp_qj),
    .disp_qk      (disp_qk),
    .disp_rob     (disp_rob),
    .full         (full),
    .cdb0_valid   (cdb0_valid),
    .cdb0_rob     (cdb0_rob),
    .cdb0_val     (cdb0_val),
    .cdb1_valid   (cdb1_valid),
    .cdb1_rob     (cdb1_rob),
    .cdb1_val     (cdb1_val),
    .alu_status   (alu_status),
    .alu_op       (alu_op),
    .alu_rs1      (alu_rs1),
    .alu_rs2      (alu_rs2),
    .alu_rob      (alu_rob)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [OpSize-1:0] op;
    logic [31:0]       rs1;
    logic [31:0]       rs2;
    logic [TAG_W-1:0]  rob;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Every issue strobe must match the oldest queued expectation, including its cycle.
  always @(negedge clk_in) begin
    if (alu_status === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected: got op=%0d rs1=%h rs2=%h rob=%0d at cycle %0d, required no issue",
                 alu_op, alu_rs1, alu_rs2, alu_rob, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (alu_op !== e.op || alu_rs1 !== e.rs1 || alu_rs2 !== e.rs2 ||
            alu_rob !== e.rob || cyc != e.cyc) begin
          failures++;
          $display("FAIL issue_data: got op=%0d rs1=%h rs2=%h rob=%0d cyc=%0d, required op=%0d rs1=%h rs2=%h rob=%0d cyc=%0d",
                   alu_op, alu_rs1, alu_rs2, alu_rob, cyc, e.op, e.rs1, e.rs2, e.rob, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rst_in     = 1'b0;
    rdy_in     = 1'b1;
    clear      = 1'b0;
    disp_valid = 1'b0;
    cdb0_valid = 1'b0;
    cdb1_valid = 1'b0;
  endtask

  task automatic drive_disp(input logic [OpSize-1:0] op, input logic [31:0] vj,
                            input logic [31:0] vk, input logic qjb, input logic [TAG_W-1:0] qj,
                            input logic qkb, input logic [TAG_W-1:0] qk,
                            input logic [TAG_W-1:0] rob);
    disp_valid   = 1'b1;
    disp_op      = op;
    disp_vj      = vj;
    disp_vk      = vk;
    disp_qj_busy = qjb;
    disp_qj      = qj;
    disp_qk_busy = qkb;
    disp_qk      = qk;
    disp_rob     = rob;
  endtask

  task automatic push_exp(input logic [OpSize-1:0] op, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [TAG_W-1:0] rob, input int c);
    exp_t e;
    e.op  = op;
    e.rs1 = rs1;
    e.rs2 = rs2;
    e.rob = rob;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) step();
    idle();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b required 0", full); end
    checks++; if (alu_status !== 1'b0) begin failures++; $display("FAIL reset_status: got %b required 0", alu_status); end
    checks++; if (alu_op !== '0) begin failures++; $display("FAIL reset_op: got %0d required 0", alu_op); end
    checks++; if (alu_rs1 !== 32'd0) begin failures++; $display("FAIL reset_rs1: got %h required 0", alu_rs1); end
    checks++; if (alu_rs2 !== 32'd0) begin failures++; $display("FAIL reset_rs2: got %h required 0", alu_rs2); end
    checks++; if (alu_rob !== '0) begin failures++; $display("FAIL reset_rob: got %0d required 0", alu_rob); end
  endtask

  task automatic test_add();
    int k;
    k = cyc;
    drive_disp(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
    push_exp(OP_ADD, 32'd5, 32'd7, 4'd6, k + 2);
    step(); idle();
    checks++; if (alu_status !== 1'b0) begin failures++; $display("FAIL add_early: got %b required 0", alu_status); end
    step();
    checks++; if (alu_status !== 1'b1) begin failures++; $display("FAIL add_status: got %b required 1", alu_status); end
    step();
    checks++; if (alu_status !== 1'b0) begin failures++; $display("FAIL add_drop: got %b required 0", alu_status); end
    checks++;
    if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7) begin
      failures++; $display("FAIL add_hold: got rs1=%h rs2=%h required 5 7", alu_rs1, alu_rs2);
    end
  endtask

  task automatic test_cdb_wakeup();
    int k;
    k = cyc;
    drive_disp(OP_SUB, 32'hDEAD_BEEF, 32'h22, 1'b1, 4'd3, 1'b0, 4'd0, 4'd1);
    push_exp(OP_SUB, 32'h10, 32'h22, 4'd1, k + 5);
    step(); idle();
    repeat (2) step();
    cdb1_valid = 1'b1; cdb1_rob = 4'd3; cdb1_val = 32'h10;
    step(); idle();
    checks++; if (alu_status !== 1'b0) begin failures++; $display("FAIL wake_early: got %b required 0", alu_status); end
    step();
    checks++; if (alu_status !== 1'b1) begin failures++; $display("FAIL wake_status: got %b required 1", alu_status); end
    step();
  endtask

  task automatic test_cdb_priority();
    int k;
    k = cyc;
    drive_disp(OP_XOR, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 4'd5, 1'b1, 4'd6, 4'd2);
    push_exp(OP_XOR, 32'h111, 32'h333, 4'd2, k + 4);
    step(); idle();
    cdb0_valid = 1'b1; cdb0_rob = 4'd5; cdb0_val = 32'h111;
    cdb1_valid = 1'b1; cdb1_rob = 4'd5; cdb1_val = 32'h222;
    step(); idle();
    cdb0_valid = 1'b1; cdb0_rob = 4'd7; cdb0_val = 32'h777;
    cdb1_valid = 1'b1; cdb1_rob = 4'd6; cdb1_val = 32'h333;
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_bypass();
    int k;
    k = cyc;
    drive_disp(OP_AND, 32'd3, 32'hAAAA_AAAA, 1'b0, 4'd0, 1'b1, 4'd2, 4'd9);
    cdb0_valid = 1'b1; cdb0_rob = 4'd2; cdb0_val = 32'd9;
    push_exp(OP_AND, 32'd3, 32'd9, 4'd9, k + 2);
    step(); idle();
    drive_disp(OP_OR, 32'h5555_5555, 32'd1, 1'b1, 4'd7, 1'b0, 4'd0, 4'd10);
    cdb1_valid = 1'b1; cdb1_rob = 4'd7; cdb1_val = 32'h77;
    push_exp(OP_OR, 32'h77, 32'd1, 4'd10, k + 3);
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_full();
    int k;
    k = cyc;
    for (int i = 0; i < RS_SIZE; i++) begin
      drive_disp(OP_ADD, 32'hBAD, 32'h100 + i, 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
      step();
      if (i == RS_SIZE - 2) begin
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_early: got %b required 0", full); end
      end
    end
    idle();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_set: got %b required 1", full); end
    drive_disp(OP_SUB, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    step(); idle();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_ignore: got %b required 1", full); end
    cdb0_valid = 1'b1; cdb0_rob = 4'd8; cdb0_val = 32'hAA;
    push_exp(OP_ADD, 32'hAA, 32'h100, 4'd0, k + 11);
    step(); idle();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_ready_hold: got %b required 1", full); end
    step();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_release: got %b required 0", full); end
    drive_disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd12);
    step(); idle();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_refill: got %b required 1", full); end
    clear = 1'b1;
    step(); idle();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_clear: got %b required 0", full); end
    cdb0_valid = 1'b1; cdb0_rob = 4'd9;  cdb0_val = 32'd1;
    cdb1_valid = 1'b1; cdb1_rob = 4'd10; cdb1_val = 32'd2;
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_ready_order();
    int k;
    for (int i = 0; i < 5; i++) begin
      drive_disp(OP_OR, 32'd0, 32'h40 + i, 1'b1, (i == 1 || i == 4) ? 4'd11 : 4'd10,
                 1'b0, 4'd0, 4'(i));
      step();
    end
    idle();
    k = cyc;
    cdb1_valid = 1'b1; cdb1_rob = 4'd11; cdb1_val = 32'h55;
    push_exp(OP_OR, 32'h55, 32'h41, 4'd1, k + 2);
    push_exp(OP_OR, 32'h55, 32'h44, 4'd4, k + 4);
    step(); idle();
    step();
    rdy_in = 1'b0;
    cdb0_valid = 1'b1; cdb0_rob = 4'd10; cdb0_val = 32'h66;
    step(); idle();
    checks++; if (alu_status !== 1'b0) begin failures++; $display("FAIL rdy_status: got %b required 0", alu_status); end
    checks++; if (alu_rob !== 4'd1) begin failures++; $display("FAIL rdy_hold_rob: got %0d required 1", alu_rob); end
    repeat (3) step();
    clear = 1'b1;
    step(); idle();
    step();
  endtask

  task automatic test_clear();
    int k;
    drive_disp(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd12, 1'b0, 4'd0, 4'd3);
    step();
    drive_disp(OP_SUB, 32'd0, 32'd2, 1'b0, 4'd0, 1'b1, 4'd13, 4'd4);
    step();
    drive_disp(OP_AND, 32'h5, 32'h6, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    step(); idle();
    clear = 1'b1;
    cdb0_valid = 1'b1; cdb0_rob = 4'd12; cdb0_val = 32'h1;
    drive_disp(OP_XOR, 32'd7, 32'd8, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
    step(); idle();
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL clear_full: got %b required 0", full); end
    checks++; if (alu_status !== 1'b0) begin failures++; $display("FAIL clear_status: got %b required 0", alu_status); end
    cdb0_valid = 1'b1; cdb0_rob = 4'd12; cdb0_val = 32'h1;
    cdb1_valid = 1'b1; cdb1_rob = 4'd13; cdb1_val = 32'h2;
    step(); idle();
    repeat (4) step();
    k = cyc;
    drive_disp(OP_ADD, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    push_exp(OP_ADD, 32'h11, 32'h22, 4'd8, k + 2);
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    drive_disp(OP_ADD, 32'h99, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
    step(); idle();
    rst_in = 1'b1;
    step(); idle();
    checks++; if (alu_status !== 1'b0) begin failures++; $display("FAIL rstmid_status: got %b required 0", alu_status); end
    checks++; if (alu_rs1 !== 32'd0) begin failures++; $display("FAIL rstmid_rs1: got %h required 0", alu_rs1); end
    checks++; if (alu_op !== '0) begin failures++; $display("FAIL rstmid_op: got %0d required 0", alu_op); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rstmid_full: got %b required 0", full); end
    repeat (4) step();
  endtask

  initial begin
    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    clear        = 1'b0;
    disp_valid   = 1'b0;
    disp_op      = '0;
    disp_vj      = '0;
    disp_vk      = '0;
    disp_qj_busy = 1'b0;
    disp_qk_busy = 1'b0;
    disp_qj      = '0;
    disp_qk      = '0;
    disp_rob     = '0;
    cdb0_valid   = 1'b0;
    cdb0_rob     = '0;
    cdb0_val     = '0;
    cdb1_valid   = 1'b0;
    cdb1_rob     = '0;
    cdb1_val     = '0;

    test_reset();
    test_add();
    test_cdb_wakeup();
    test_cdb_priority();
    test_bypass();
    test_full();
    test_ready_order();
    test_clear();
    test_reset_mid();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL issue_missing: got %0d issues still outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
